// File: rtl/line_filter_pipe.sv
// line_filter_pipe: prefetches one LCD line of RGB888 pixels from SDRAM, applies a per-frame
// point or 3-tap horizontal filter, and queues the results in a FIFO popped by the LCD.
module line_filter_pipe #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_RD_START = 214,
    parameter int V_RD_START = 34,
    parameter int LEAD       = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Clock_en,
    input  logic        Enable,
    input  logic [2:0]  Filter_config,
    input  logic [10:0] H_Count,
    input  logic [9:0]  V_Count,
    output logic        oRead_in_en,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
    input  logic        iRead_out_en,
    output logic [7:0]  R_out,
    output logic [7:0]  G_out,
    output logic [7:0]  B_out,
    output logic        oUnderflow
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [10:0] H_START = 11'(H_RD_START - LEAD);
    localparam logic [9:0]  V_FIRST = 10'(V_RD_START);
    localparam logic [9:0]  V_LAST  = 10'(V_RD_START + V_ACTIVE - 1);
    localparam logic [9:0]  RD_LAST = 10'(H_ACTIVE - 1);
    localparam logic [AW:0] FULL    = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] F_GRAY   = 3'd1;
    localparam logic [2:0] F_INVERT = 3'd2;
    localparam logic [2:0] F_BLUR   = 3'd3;
    localparam logic [2:0] F_EDGE   = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH, S_WAIT} state_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // (x + 2y + z) >> 2 with a 10-bit sum; shared by blur and gray.
    function automatic logic [7:0] tap121(input logic [7:0] x, input logic [7:0] y,
                                          input logic [7:0] z);
        logic [9:0] sum;
        sum = {2'b00, x} + {1'b0, y, 1'b0} + {2'b00, z};
        return sum[9:2];
    endfunction

    function automatic logic [7:0] absdiff(input logic [7:0] x, input logic [7:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    state_t        state_q, state_d;
    logic [9:0]    rd_cnt_q, rd_cnt_d;
    logic          in_valid_q, in_valid_d;
    logic          have_pix_q, have_pix_d;
    rgb_t          win_a_q, win_a_d, win_b_q, win_b_d, win_c_q, win_c_d;
    logic          win_valid_q, win_valid_d;
    rgb_t          alu_q, alu_d;
    logic          alu_valid_q, alu_valid_d;
    logic [2:0]    cfg_q, cfg_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    rgb_t          out_q, out_d;
    logic          underflow_q, underflow_d;
    rgb_t          fifo_mem_q [FIFO_DEPTH];

    rgb_t       pix_in, alu_res;
    logic [7:0] gray;
    logic       rd_en, start, v_in_range, empty, full, do_push, do_pop;

    assign pix_in     = {R_in, G_in, B_in};
    assign v_in_range = (V_Count >= V_FIRST) && (V_Count <= V_LAST);
    assign start      = Enable && v_in_range && (H_Count == H_START);
    assign rd_en      = Enable && (state_q == S_FETCH) && !Clock_en;
    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL);
    assign do_push    = Enable && alu_valid_q && !full;
    assign do_pop     = Enable && iRead_out_en && !empty;
    assign gray       = tap121(win_b_q.r, win_b_q.g, win_b_q.b);

    assign oRead_in_en = rd_en;
    assign R_out       = out_q.r;
    assign G_out       = out_q.g;
    assign B_out       = out_q.b;
    assign oUnderflow  = underflow_q;

    always_comb begin
        alu_res = win_b_q;
        case (cfg_q)
            F_GRAY:   alu_res = {gray, gray, gray};
            F_INVERT: alu_res = {8'd255 - win_b_q.r, 8'd255 - win_b_q.g, 8'd255 - win_b_q.b};
            F_BLUR:   alu_res = {tap121(win_a_q.r, win_b_q.r, win_c_q.r),
                                 tap121(win_a_q.g, win_b_q.g, win_c_q.g),
                                 tap121(win_a_q.b, win_b_q.b, win_c_q.b)};
            F_EDGE:   alu_res = {absdiff(win_c_q.r, win_a_q.r),
                                 absdiff(win_c_q.g, win_a_q.g),
                                 absdiff(win_c_q.b, win_a_q.b)};
            default:  alu_res = win_b_q;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts as a hold of its _q, so no branch below can infer a latch.
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        in_valid_d  = rd_en;
        have_pix_d  = have_pix_q;
        win_a_d     = win_a_q;
        win_b_d     = win_b_q;
        win_c_d     = win_c_q;
        win_valid_d = 1'b0;
        alu_d       = win_valid_q ? alu_res : alu_q;
        alu_valid_d = win_valid_q;
        cfg_d       = cfg_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_d       = out_q;
        underflow_d = underflow_q;

        if (V_Count == '0 && H_Count == '0) cfg_d = Filter_config;

        case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_FETCH;
                rd_cnt_d   = '0;
                have_pix_d = 1'b0;
            end
            S_FETCH: if (rd_en) begin
                if (rd_cnt_q == RD_LAST) state_d = S_FLUSH;
                else                     rd_cnt_d = rd_cnt_q + 1'b1;
            end
            // Once the last pixel has landed, shift once more with the right edge replicated.
            S_FLUSH: if (!in_valid_q) begin
                win_a_d     = win_b_q;
                win_b_d     = win_c_q;
                win_valid_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: if (H_Count != H_START) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (in_valid_q) begin
            have_pix_d = 1'b1;
            win_c_d    = pix_in;
            if (!have_pix_q) begin
                win_a_d = pix_in;
                win_b_d = pix_in;
            end else begin
                win_a_d     = win_b_q;
                win_b_d     = win_c_q;
                win_valid_d = 1'b1;
            end
        end

        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (iRead_out_en) begin
            if (empty) begin
                out_d       = '0;
                underflow_d = 1'b1;
            end else begin
                out_d = fifo_mem_q[rd_ptr_q];
            end
        end

        if (!Enable) begin
            state_d     = S_IDLE;
            rd_cnt_d    = '0;
            in_valid_d  = 1'b0;
            have_pix_d  = 1'b0;
            win_a_d     = '0;
            win_b_d     = '0;
            win_c_d     = '0;
            win_valid_d = 1'b0;
            alu_d       = '0;
            alu_valid_d = 1'b0;
            cfg_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_d       = '0;
            underflow_d = 1'b0;
        end
    end

    // NOTE: the storage array is not reset; count and pointers alone decide which entries are
    // live, and leaving it reset-free lets it map onto RAM.
    always_ff @(posedge Clock) begin
        if (do_push) fifo_mem_q[wr_ptr_q] <= alu_q;
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            in_valid_q  <= 1'b0;
            have_pix_q  <= 1'b0;
            win_a_q     <= '0;
            win_b_q     <= '0;
            win_c_q     <= '0;
            win_valid_q <= 1'b0;
            alu_q       <= '0;
            alu_valid_q <= 1'b0;
            cfg_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            in_valid_q  <= in_valid_d;
            have_pix_q  <= have_pix_d;
            win_a_q     <= win_a_d;
            win_b_q     <= win_b_d;
            win_c_q     <= win_c_d;
            win_valid_q <= win_valid_d;
            alu_q       <= alu_d;
            alu_valid_q <= alu_valid_d;
            cfg_q       <= cfg_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_line_filter_pipe.sv
// Directed bench for line_filter_pipe: drives the LCD counters and an SDRAM pixel source line by
// line, pops every active pixel and compares it with hand-computed expected values.
module tb_line_filter_pipe;
    localparam int H_ACTIVE   = 640;
    localparam int H_RD_START = 214;
    localparam int LEAD       = 4;
    localparam int V_RD_START = 34;
    localparam int H_TOTAL    = 870;

    logic        Clock = 1'b0;
    logic        Resetn, Clock_en, Enable, iRead_out_en, oRead_in_en, oUnderflow;
    logic [2:0]  Filter_config;
    logic [10:0] H_Count;
    logic [9:0]  V_Count;
    logic [7:0]  R_in, G_in, B_in, R_out, G_out, B_out;

    int vectors     = 0;
    int miscompares = 0;
    int rd_idx, pop_idx, reads_after_drop;

    logic [7:0] pix_r [H_ACTIVE];
    logic [7:0] pix_g [H_ACTIVE];
    logic [7:0] pix_b [H_ACTIVE];
    logic [7:0] exp_r [H_ACTIVE];
    logic [7:0] exp_g [H_ACTIVE];
    logic [7:0] exp_b [H_ACTIVE];

    line_filter_pipe dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .Clock_en      (Clock_en),
        .Enable        (Enable),
        .Filter_config (Filter_config),
        .H_Count       (H_Count),
        .V_Count       (V_Count),
        .oRead_in_en   (oRead_in_en),
        .R_in          (R_in),
        .G_in          (G_in),
        .B_in          (B_in),
        .iRead_out_en  (iRead_out_en),
        .R_out         (R_out),
        .G_out         (G_out),
        .B_out         (B_out),
        .oUnderflow    (oUnderflow)
    );

    always #10 Clock = ~Clock;

    task automatic fill(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        for (int x = 0; x < H_ACTIVE; x++) begin
            pix_r[x] = r;  pix_g[x] = g;  pix_b[x] = b;
            exp_r[x] = er; exp_g[x] = eg; exp_b[x] = eb;
        end
    endtask

    task automatic frame_start(input logic [2:0] cfg);
        V_Count       = 10'd0;
        H_Count       = 11'd0;
        Filter_config = cfg;
        for (int ph = 0; ph < 2; ph++) begin
            Clock_en = (ph == 1);
            @(posedge Clock); #1;
        end
    endtask

    // One LCD line, two clocks per H_Count value; pops compared against exp_* when pop_en.
    task automatic run_line(input int drop_h, input bit pop_en, input string name);
        logic rd_seen;
        rd_idx           = 0;
        pop_idx          = 0;
        reads_after_drop = 0;
        V_Count          = 10'(V_RD_START + 5);
        for (int h = 0; h < H_TOTAL; h++) begin
            for (int ph = 0; ph < 2; ph++) begin
                H_Count  = 11'(h);
                Clock_en = (ph == 1);
                if (drop_h >= 0 && h == drop_h && ph == 0)     Enable = 1'b0;
                if (drop_h >= 0 && h == drop_h + 2 && ph == 0) Enable = 1'b1;
                iRead_out_en = pop_en && (ph == 1) && (h >= H_RD_START) &&
                               (h < H_RD_START + H_ACTIVE);
                #1;
                rd_seen = oRead_in_en;
                if (rd_seen && drop_h >= 0 && h >= drop_h) reads_after_drop++;
                @(posedge Clock); #1;
                if (rd_seen) begin
                    if (rd_idx < H_ACTIVE) begin
                        R_in = pix_r[rd_idx]; G_in = pix_g[rd_idx]; B_in = pix_b[rd_idx];
                    end
                    rd_idx++;
                end
                if (iRead_out_en) begin
                    vectors++;
                    if ({R_out, G_out, B_out} !== {exp_r[pop_idx], exp_g[pop_idx], exp_b[pop_idx]}) begin
                        miscompares++;
                        $display("FAIL %s pixel %0d: got %h_%h_%h expected %h_%h_%h", name, pop_idx,
                                 R_out, G_out, B_out, exp_r[pop_idx], exp_g[pop_idx], exp_b[pop_idx]);
                    end
                    pop_idx++;
                end
            end
        end
        iRead_out_en = 1'b0;
    endtask

    task automatic end_of_line_checks(input string name);
        vectors++;
        if (rd_idx !== H_ACTIVE) begin
            miscompares++;
            $display("FAIL %s read count: got %0d expected %0d", name, rd_idx, H_ACTIVE);
        end
        vectors++;
        if (oUnderflow !== 1'b0) begin
            miscompares++;
            $display("FAIL %s underflow: got %b expected 0", name, oUnderflow);
        end
    endtask

    task automatic test_reset;
        Resetn = 1'b0; Enable = 1'b1; Clock_en = 1'b0; Filter_config = 3'd0;
        H_Count = 11'(H_RD_START - LEAD); V_Count = 10'(V_RD_START);
        iRead_out_en = 1'b0; R_in = '0; G_in = '0; B_in = '0;
        repeat (3) @(posedge Clock);
        #1;
        vectors++;
        if ({oRead_in_en, R_out, G_out, B_out, oUnderflow} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset outputs: got rd=%b rgb=%h_%h_%h unf=%b expected all 0",
                     oRead_in_en, R_out, G_out, B_out, oUnderflow);
        end
        H_Count = 11'd100;
        Resetn  = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_pass_ramp;
        frame_start(3'd0);
        for (int x = 0; x < H_ACTIVE; x++) begin
            pix_r[x] = 8'(x); pix_g[x] = 8'(x); pix_b[x] = 8'(x);
            exp_r[x] = 8'(x); exp_g[x] = 8'(x); exp_b[x] = 8'(x);
        end
        run_line(-1, 1'b1, "pass_ramp");
        end_of_line_checks("pass_ramp");
    endtask

    task automatic test_blur;
        frame_start(3'd3);
        fill(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        pix_r[12] = 8'd100; pix_g[12] = 8'd100; pix_b[12] = 8'd100;
        exp_r[11] = 8'd25;  exp_g[11] = 8'd25;  exp_b[11] = 8'd25;
        exp_r[12] = 8'd50;  exp_g[12] = 8'd50;  exp_b[12] = 8'd50;
        exp_r[13] = 8'd25;  exp_g[13] = 8'd25;  exp_b[13] = 8'd25;
        run_line(-1, 1'b1, "blur_impulse");
        end_of_line_checks("blur_impulse");
        // Edges: p0=p1=200 on the left, p639=200 on the right, zeros elsewhere.
        fill(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int x = 0; x < 2; x++) begin
            pix_r[x] = 8'd200; pix_g[x] = 8'd200; pix_b[x] = 8'd200;
        end
        pix_r[639] = 8'd200; pix_g[639] = 8'd200; pix_b[639] = 8'd200;
        exp_r[0] = 8'd200;   exp_g[0] = 8'd200;   exp_b[0] = 8'd200;
        exp_r[1] = 8'd150;   exp_g[1] = 8'd150;   exp_b[1] = 8'd150;
        exp_r[2] = 8'd50;    exp_g[2] = 8'd50;    exp_b[2] = 8'd50;
        exp_r[638] = 8'd50;  exp_g[638] = 8'd50;  exp_b[638] = 8'd50;
        exp_r[639] = 8'd150; exp_g[639] = 8'd150; exp_b[639] = 8'd150;
        run_line(-1, 1'b1, "blur_edges");
        end_of_line_checks("blur_edges");
    endtask

    task automatic test_edge;
        frame_start(3'd4);
        fill(8'd90, 8'd90, 8'd90, 8'd0, 8'd0, 8'd0);
        for (int x = 0; x < 5; x++) begin
            pix_r[x] = 8'd10; pix_g[x] = 8'd10; pix_b[x] = 8'd10;
        end
        exp_r[4] = 8'd80; exp_g[4] = 8'd80; exp_b[4] = 8'd80;
        exp_r[5] = 8'd80; exp_g[5] = 8'd80; exp_b[5] = 8'd80;
        run_line(-1, 1'b1, "edge_step");
        end_of_line_checks("edge_step");
    endtask

    task automatic test_gray_invert;
        frame_start(3'd1);
        Filter_config = 3'd2;
        fill(8'd255, 8'd0, 8'd255, 8'd127, 8'd127, 8'd127);
        run_line(-1, 1'b1, "gray_midframe_cfg");
        end_of_line_checks("gray_midframe_cfg");
        frame_start(3'd2);
        fill(8'h12, 8'h12, 8'h12, 8'hED, 8'hED, 8'hED);
        run_line(-1, 1'b1, "invert");
        end_of_line_checks("invert");
    endtask

    task automatic test_underflow;
        H_Count = 11'd5; V_Count = 10'd600; Clock_en = 1'b0;
        iRead_out_en = 1'b1;
        @(posedge Clock); #1;
        iRead_out_en = 1'b0;
        vectors++;
        if ({R_out, G_out, B_out, oUnderflow} !== 25'h1) begin
            miscompares++;
            $display("FAIL empty_pop: got rgb=%h_%h_%h unf=%b expected 00_00_00 unf=1",
                     R_out, G_out, B_out, oUnderflow);
        end
        repeat (5) @(posedge Clock);
        #1;
        vectors++;
        if (oUnderflow !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_sticky: got %b expected 1", oUnderflow);
        end
        Enable = 1'b0;
        @(posedge Clock); #1;
        Enable = 1'b1;
        vectors++;
        if (oUnderflow !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_clear: got %b expected 0", oUnderflow);
        end
    endtask

    task automatic test_enable_drop;
        frame_start(3'd0);
        for (int x = 0; x < H_ACTIVE; x++) begin
            pix_r[x] = 8'(x); pix_g[x] = 8'(x); pix_b[x] = 8'(x);
            exp_r[x] = 8'(x); exp_g[x] = 8'(x); exp_b[x] = 8'(x);
        end
        run_line(H_RD_START - LEAD + 300, 1'b0, "enable_drop");
        vectors++;
        if (reads_after_drop !== 0) begin
            miscompares++;
            $display("FAIL enable_drop reads after drop: got %0d expected 0", reads_after_drop);
        end
        run_line(-1, 1'b1, "after_enable_drop");
        vectors++;
        if (pop_idx !== H_ACTIVE) begin
            miscompares++;
            $display("FAIL after_enable_drop pops: got %0d expected %0d", pop_idx, H_ACTIVE);
        end
        end_of_line_checks("after_enable_drop");
    endtask

    initial begin
        test_reset();
        test_pass_ramp();
        test_blur();
        test_edge();
        test_gray_invert();
        test_underflow();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
